// File: rtl/athos_ip_pkg.sv
// athos_ip_pkg: shared widths, packer state encoding and pad constants for the ATHOS input stage
package athos_ip_pkg;
  localparam int ATHOS_STATE_W = 1600;
  localparam int ATHOS_WORD_W = 32;
  localparam int ATHOS_NUM_WORDS = ATHOS_STATE_W / ATHOS_WORD_W;
  localparam logic [7:0] ATHOS_PAD_LAST_BYTE = 8'h80;
  typedef enum logic [1:0] {PK_FILL, PK_PAD, PK_FULL} packer_state_e;
endpackage

// File: rtl/athos_ip_din_packer_if.sv
// athos_ip_din_packer_if: word-write and block-handoff signals between software-facing writer and packer
interface athos_ip_din_packer_if;
  import athos_ip_pkg::*;
  logic clear;
  logic [5:0] rate;
  logic [7:0] domain;
  logic [ATHOS_WORD_W-1:0] word;
  logic word_we;
  logic word_last;
  logic [2:0] word_nbytes;
  logic word_ready;
  logic [ATHOS_STATE_W-1:0] block;
  logic block_valid;
  logic block_ready;
  logic msg_done;
  logic [15:0] block_cnt;
  modport master (
    output clear, rate, domain, word, word_we, word_last, word_nbytes, block_ready,
    input word_ready, block, block_valid, msg_done, block_cnt
  );
  modport slave (
    input clear, rate, domain, word, word_we, word_last, word_nbytes, block_ready,
    output word_ready, block, block_valid, msg_done, block_cnt
  );
endinterface

// File: rtl/athos_ip_pad_word.sv
// athos_ip_pad_word: masks trailing bytes of a last word, optionally drops the domain byte after the data and sets the final 0x80 bit
module athos_ip_pad_word
  import athos_ip_pkg::*;
(
  input  logic [ATHOS_WORD_W-1:0] word,
  input  logic [2:0]              nbytes,
  input  logic [7:0]              domain,
  input  logic                    is_last,
  input  logic                    pad_en,
  input  logic                    set_msb,
  output logic [ATHOS_WORD_W-1:0] padded
);
  // byte b survives unless the word is last and b is past the data; the first byte past the data may carry the domain
  always_comb begin
    padded = '0;
    for (int b = 0; b < 4; b++)
      padded[8*b +: 8] = (!is_last || 3'(b) < nbytes) ? word[8*b +: 8] :
                         (pad_en && 3'(b) == nbytes) ? domain : 8'h00;
    if (set_msb) padded[31:24] = padded[31:24] | ATHOS_PAD_LAST_BYTE;
  end
endmodule

// File: rtl/athos_ip_din_packer.sv
// athos_ip_din_packer: packs 32-bit words into a 1600-bit Keccak block; hardware pad10*1 when ATHOS_DIN_PAD_EN is defined
module athos_ip_din_packer
  import athos_ip_pkg::*;
(
  input logic clk,
  input logic rst_n,
  athos_ip_din_packer_if.slave bus
);
  localparam logic [1:0] S_FILL = 2'(PK_FILL);
  localparam logic [1:0] S_PAD = 2'(PK_PAD);
  localparam logic [1:0] S_FULL = 2'(PK_FULL);
  logic [1:0] state;
  logic [ATHOS_STATE_W-1:0] blk;
  logic [5:0] ptr, rate_q, rate_eff, r;
  logic [7:0] dom_q, d;
  logic pad_pending, final_q;
  logic [15:0] cnt;
  logic acc, hs, pad_en, last_full, wrap, set_msb;
  logic [10:0] base, nbase, mbase;
  logic [ATHOS_WORD_W-1:0] pw;
`ifdef ATHOS_DIN_PAD_EN
  assign pad_en = 1'b1;
`else
  assign pad_en = 1'b0;
`endif
  // rate/domain come from the bus on the first word of a block, otherwise from the values held for that block
  always_comb begin
    rate_eff = (bus.rate == 6'd0 || bus.rate > 6'(ATHOS_NUM_WORDS)) ? 6'(ATHOS_NUM_WORDS) : bus.rate;
    r = (state == S_FILL && ptr == 6'd0) ? rate_eff : rate_q;
    d = (state == S_FILL && ptr == 6'd0) ? bus.domain : dom_q;
    acc = state == S_FILL && bus.word_we;
    hs = state == S_FULL && bus.block_ready;
    last_full = bus.word_nbytes >= 3'd4;
    wrap = ptr + 6'd1 == r;
    set_msb = pad_en && bus.word_last && !last_full && wrap;
    base = {ptr, 5'd0};
    nbase = base + 11'd32;
    mbase = {r - 6'd1, 5'd0};
  end
  athos_ip_pad_word u_pad (
    .word(bus.word),
    .nbytes(bus.word_nbytes),
    .domain(d),
    .is_last(bus.word_last),
    .pad_en(pad_en),
    .set_msb(set_msb),
    .padded(pw)
  );
  // fill / pad / full sequencing with clear overriding any write or handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_FILL;
      blk <= '0;
      ptr <= '0;
      rate_q <= 6'(ATHOS_NUM_WORDS);
      dom_q <= '0;
      pad_pending <= 1'b0;
      final_q <= 1'b0;
      cnt <= '0;
    end else if (bus.clear) begin
      state <= S_FILL;
      blk <= '0;
      ptr <= '0;
      rate_q <= 6'(ATHOS_NUM_WORDS);
      dom_q <= '0;
      pad_pending <= 1'b0;
      final_q <= 1'b0;
      cnt <= '0;
    end else if (acc) begin
      blk[base +: 32] <= pw;
      ptr <= ptr + 6'd1;
      if (ptr == 6'd0) begin
        rate_q <= r;
        dom_q <= d;
      end
      if (bus.word_last && pad_en) begin
        if (last_full && wrap) pad_pending <= 1'b1;
        else begin
          blk[mbase + 11'd31] <= 1'b1;
          if (last_full) blk[nbase +: 8] <= d;
        end
      end
      final_q <= bus.word_last && !(pad_en && last_full && wrap);
      if (bus.word_last || wrap) state <= S_FULL;
    end else if (hs) begin
      blk <= '0;
      ptr <= '0;
      cnt <= cnt + 16'd1;
      final_q <= 1'b0;
      state <= pad_pending ? S_PAD : S_FILL;
    end else if (state == S_PAD) begin
      blk[7:0] <= dom_q;
      blk[mbase + 11'd31] <= 1'b1;
      pad_pending <= 1'b0;
      final_q <= 1'b1;
      state <= S_FULL;
    end
  assign bus.word_ready = state == S_FILL;
  assign bus.block_valid = state == S_FULL;
  assign bus.block = blk;
  assign bus.msg_done = hs && final_q && !bus.clear;
  assign bus.block_cnt = cnt;
endmodule

// File: tb/tb_athos_ip_din_packer.sv
// tb_athos_ip_din_packer: randomized byte-stream reference model with a scoreboard of expected blocks
module tb_athos_ip_din_packer;
  import athos_ip_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  athos_ip_din_packer_if bus();
  athos_ip_din_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int rdy_mode = 1;
  logic [ATHOS_STATE_W-1:0] exp_blk[$];
  bit exp_fin[$];
  logic [31:0] msg_q[$];
  logic [ATHOS_STATE_W-1:0] held;
  bit held_v = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkblk(input string name, input logic [ATHOS_STATE_W-1:0] act, input logic [ATHOS_STATE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < ATHOS_NUM_WORDS; k++)
        if (act[32*k +: 32] !== exp[32*k +: 32]) begin
          $display("FAIL %s word %0d: got %h expected %h", name, k, act[32*k +: 32], exp[32*k +: 32]);
          break;
        end
    end
  endtask

  // block_ready is randomized when rdy_mode==0; directed sections drive it themselves
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) bus.block_ready = 1'($urandom_range(0, 1));
  end

  // monitor: pops an expected block on every handshake and checks the side conditions each cycle
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_cnt = 0;
      held_v = 0;
      continue;
    end
    if (bus.clear) begin
      chk("msg_done_on_clear", 32'(bus.msg_done), 32'd0);
      exp_cnt = 0;
      held_v = 0;
      continue;
    end
    if (bus.block_valid) chk("word_ready_while_full", 32'(bus.word_ready), 32'd0);
    if (held_v && bus.block_valid) chkblk("block_stable", bus.block, held);
    held_v = bus.block_valid && !bus.block_ready;
    held = bus.block;
    if (bus.block_valid && bus.block_ready) begin
      if (exp_blk.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block: got block %0d expected none", exp_cnt);
      end else begin
        chkblk("block", bus.block, exp_blk.pop_front());
        chk("msg_done", 32'(bus.msg_done), 32'(exp_fin.pop_front()));
        chk("block_cnt", 32'(bus.block_cnt), 32'(exp_cnt & 16'hFFFF));
        exp_cnt++;
      end
    end else if (bus.block_valid || bus.msg_done) chk("msg_done_idle", 32'(bus.msg_done), 32'd0);
  end

  task automatic put(input logic [31:0] w, input bit last, input logic [2:0] nb);
    int t = 0;
    bus.word = w;
    bus.word_last = last;
    bus.word_nbytes = nb;
    bus.word_we = 1'b1;
    while (!bus.word_ready) begin
      @(posedge clk);
      #1;
      if (++t > 500) begin
        checks++;
        errors++;
        $display("FAIL word_accept_timeout: got word_ready=0 for %0d cycles expected 1", t);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.word_we = 1'b0;
    bus.word_last = 1'b0;
  endtask

  // reference: message as a byte stream, padded to whole rate-sized blocks, then cut into blocks
  task automatic send_msg(input int nw, input logic [5:0] rate, input logic [7:0] dom, input logic [2:0] nb,
                          input bit rnd, input logic [31:0] fill, input bit ends);
    logic [7:0] q[$];
    logic [ATHOS_STATE_W-1:0] b;
    int rb;
    int nblk;
    rb = 4 * ((rate == 0 || rate > 50) ? 50 : int'(rate));
    msg_q.delete();
    for (int i = 0; i < nw; i++) msg_q.push_back(rnd ? $urandom : fill);
    for (int i = 0; i < nw; i++)
      for (int j = 0; j < ((ends && i == nw - 1) ? int'(nb) : 4); j++) q.push_back(msg_q[i][8*j +: 8]);
    if (ends) begin
`ifdef ATHOS_DIN_PAD_EN
      q.push_back(dom);
`endif
      while (q.size() % rb != 0) q.push_back(8'h00);
`ifdef ATHOS_DIN_PAD_EN
      q[q.size()-1] = q[q.size()-1] | 8'h80;
`endif
    end
    nblk = q.size() / rb;
    for (int k = 0; k < nblk; k++) begin
      b = '0;
      for (int j = 0; j < rb; j++) b[8*j +: 8] = q[k*rb + j];
      exp_blk.push_back(b);
      exp_fin.push_back(ends && k == nblk - 1);
    end
    bus.rate = rate;
    bus.domain = dom;
    for (int i = 0; i < nw; i++) put(msg_q[i], ends && i == nw - 1, nb);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_blk.size() != 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_blk.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d blocks outstanding expected 0", exp_blk.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_word_ready"}, 32'(bus.word_ready), 32'd1);
    chk({tag, "_block_valid"}, 32'(bus.block_valid), 32'd0);
    chk({tag, "_block_cnt"}, 32'(bus.block_cnt), 32'd0);
    chk({tag, "_msg_done"}, 32'(bus.msg_done), 32'd0);
    chkblk({tag, "_block"}, bus.block, '0);
  endtask

  task automatic random_msgs(input int n);
    for (int m = 0; m < n; m++)
      send_msg($urandom_range(1, 70), 6'($urandom_range(0, 63)), 8'($urandom), 3'($urandom_range(1, 4)), 1, 0, 1);
  endtask

  initial begin
    bus.clear = 1'b0;
    bus.rate = 6'd34;
    bus.domain = 8'h06;
    bus.word = '0;
    bus.word_we = 1'b0;
    bus.word_last = 1'b0;
    bus.word_nbytes = 3'd4;
    bus.block_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_checks("reset");
    // single short last word
    send_msg(1, 6'd34, 8'h06, 3'd3, 0, 32'h00636261, 1);
    chk("valid_t1", 32'(bus.block_valid), 32'd1);
`ifdef ATHOS_DIN_PAD_EN
    chk("t1_word0", bus.block[31:0], 32'h06636261);
    chk("t1_word33", bus.block[33*32 +: 32], 32'h80000000);
`else
    chk("t1_word0", bus.block[31:0], 32'h00636261);
`endif
    bus.block_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.block_ready = 1'b0;
    chk("ready_after_hs", 32'(bus.word_ready), 32'd1);
    // full block held off by the datapath
    send_msg(34, 6'd34, 8'h06, 3'd4, 0, 32'hFFFFFFFF, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("backpressure_valid", 32'(bus.block_valid), 32'd1);
    end
    bus.block_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.block_ready = 1'b0;
    // last word fills the block exactly
    send_msg(34, 6'd34, 8'h06, 3'd4, 1, 0, 1);
    bus.block_ready = 1'b1;
    @(posedge clk);
    #1;
`ifdef ATHOS_DIN_PAD_EN
    chk("pad_cycle_valid", 32'(bus.block_valid), 32'd0);
    chk("pad_cycle_ready", 32'(bus.word_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("pad_block_valid", 32'(bus.block_valid), 32'd1);
    @(posedge clk);
    #1;
`else
    chk("no_pad_ready", 32'(bus.word_ready), 32'd1);
`endif
    bus.block_ready = 1'b0;
    rdy_mode = 0;
    send_msg(1, 6'd1, 8'h1F, 3'd4, 0, 32'h11223344, 1);
    drain();
    random_msgs(30);
    drain();
    // clear collides with an 11th write
    bus.rate = 6'd34;
    for (int i = 0; i < 10; i++) put($urandom, 0, 3'd4);
    bus.word = 32'hDEADBEEF;
    bus.word_we = 1'b1;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.word_we = 1'b0;
    idle_checks("clear");
    send_msg(1, 6'd34, 8'h1F, 3'd2, 1, 0, 1);
    drain();
    // asynchronous reset in the middle of a block
    for (int i = 0; i < 5; i++) put($urandom, 0, 3'd4);
    rst_n = 1'b0;
    #2;
    idle_checks("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    random_msgs(15);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
